// File: rtl/sonic_vc_tx_pkg.sv
// Shared definitions for the VC TX FIFO output adapter.
// These are the word field offsets and the serialiser state encoding.
package sonic_vc_tx_pkg;

    localparam int unsigned SOP_BIT   = 128;
    localparam int unsigned EOP_BIT   = 129;
    localparam int unsigned ERR_BIT   = 130;
    localparam int unsigned EMPTY_LSB = 131;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HI,
        ST_LO
    } state_t;

endpackage

// File: rtl/sonic_vc_tx_fifo_out_adapter.sv
// Serialises 133-bit TX FIFO words into one or two 64-bit beats.
// It also counts forwarded packets and flags framing violations.
module sonic_vc_tx_fifo_out_adapter
    import sonic_vc_tx_pkg::*;
#(
    parameter int IN_WIDTH  = 133,
    parameter int OUT_WIDTH = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 out_empty,
    output logic                 out_error,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic                 proto_err
);

    state_t              state;
    state_t              state_nx;
    logic [IN_WIDTH-1:0] h;
    logic                in_pkt;

    logic       h_sop;
    logic       h_eop;
    logic       h_err;
    logic [1:0] h_empty;
    logic       single;
    logic       final_beat;
    logic       in_acc;
    logic       out_acc;
    logic       in_sop;
    logic       in_eop;

    assign h_sop   = h[SOP_BIT];
    assign h_eop   = h[EOP_BIT];
    assign h_err   = h[ERR_BIT];
    assign h_empty = h[EMPTY_LSB +: 2];
    assign single  = h_eop && (h_empty >= 2'd2);

    assign final_beat = ((state == ST_HI) && single) || (state == ST_LO);
    assign in_ready   = !reset && ((state == ST_EMPTY) || (out_ready && final_beat));
    assign in_acc     = in_valid && in_ready;
    assign out_acc    = out_valid && out_ready;
    assign in_sop     = in_data[SOP_BIT];
    assign in_eop     = in_data[EOP_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_EMPTY: if (in_acc) state_nx = ST_HI;
            ST_HI: begin
                if (out_ready) begin
                    if (single) state_nx = in_acc ? ST_HI : ST_EMPTY;
                    else        state_nx = ST_LO;
                end
            end
            ST_LO: if (out_ready) state_nx = in_acc ? ST_HI : ST_EMPTY;
            default: state_nx = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_empty = 1'b0;
        out_error = 1'b0;
        unique case (state)
            ST_HI: begin
                out_valid = 1'b1;
                out_data  = h[OUT_WIDTH +: OUT_WIDTH];
                out_sop   = h_sop;
                if (single) begin
                    // empty is 2 or 3 here, so empty - 2 is just its LSB
                    out_eop   = 1'b1;
                    out_empty = h_empty[0];
                    out_error = h_err;
                end
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_data  = h[0 +: OUT_WIDTH];
                out_eop   = h_eop;
                out_empty = h_eop & h_empty[0];
                out_error = h_eop & h_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h         <= '0;
            in_pkt    <= 1'b0;
            proto_err <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (in_acc) begin
                h <= in_data;
                if ((in_sop && in_pkt) || (!in_sop && !in_pkt)) proto_err <= 1'b1;
                if (in_eop)      in_pkt <= 1'b0;
                else if (in_sop) in_pkt <= 1'b1;
            end
            if (out_acc && out_eop) pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

endmodule
